// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Multi-cycle add/subtract, CHUNK bits per cycle LSB first, with
//            carry held between cycles and signed-overflow detection.
// Revision : 1.0
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf
);

    localparam int c_steps = WIDTH / CHUNK;
    localparam int c_cnt_w = $clog2(c_steps) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [CHUNK-1:0]   w_s;
    logic [CHUNK:0]     w_c;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    assign busy   = (r_state == S_RUN);
    assign w_last = busy && (r_cnt == c_last);
    assign w_c[0] = r_carry;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_fa
            assign w_s[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
            assign w_c[i+1] = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
    endgenerate

    // New sum bits enter at the top so the LSB chunk ends up at bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_res_full
            assign w_res_next = w_s;
        end else begin : g_res_shift
            assign w_res_next = {w_s, r_res[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            done    <= 1'b0;
            sum_out <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= w_last;
            if ((r_state == S_IDLE) && start) begin
                // Subtraction is a + ~b + ~cin; the inversion of cin folds into the carry seed.
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= cin ^ sub;
                r_cnt   <= '0;
            end else if (busy) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_res   <= w_res_next;
                r_carry <= w_c[CHUNK];
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_last) begin
                sum_out <= w_res_next;
                c_out   <= w_c[CHUNK];
                ovf     <= w_c[CHUNK] ^ w_c[CHUNK-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Scoreboard bench for serial_adder at 8x1 and 16x4 configurations.
// Revision : 1.0
// ============================================================================
module tb_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, cin8, sub8, busy8, done8, c8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, sub16, busy16, done16, c16, ovf16;
    logic [15:0] a16, b16, sum16;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_done8 = 0;
    int   d1 = 0;
    int   cnt = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t m8;
    exp_t m16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sub(sub8), .busy(busy8), .done(done8), .sum_out(sum8), .c_out(c8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .sub(sub16), .busy(busy16), .done(done16), .sum_out(sum16), .c_out(c16), .ovf(ovf16)
    );

    // Reference: exact integer arithmetic, overflow = true signed result out of range.
    function automatic exp_t model(int w, longint a, longint b, bit cin, bit sub);
        exp_t   e;
        longint m, half, u, sa, sb, s, ci;
        ci   = cin ? 1 : 0;
        m    = longint'(1) << w;
        half = m / 2;
        if (sub) begin
            u   = a - b - ci;
            e.c = (a >= b + ci);
        end else begin
            u   = a + b + ci;
            e.c = (u >= m);
        end
        e.sum = 16'(u & (m - 1));
        sa    = (a >= half) ? a - m : a;
        sb    = (b >= half) ? b - m : b;
        s     = sub ? sa - sb - ci : sa + sb + ci;
        e.v   = (s >= half) || (s < -half);
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                m8 = q8.pop_front();
                chk("sum8", int'(sum8), int'(m8.sum[7:0]));
                chk("cout8", int'(c8), int'(m8.c));
                chk("ovf8", int'(ovf8), int'(m8.v));
                chk("latency8", cyc - m8.acc, 8);
                last_done8 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                m16 = q16.pop_front();
                chk("sum16", int'(sum16), int'(m16.sum));
                chk("cout16", int'(c16), int'(m16.c));
                chk("ovf16", int'(ovf16), int'(m16.v));
                chk("latency16", cyc - m16.acc, 4);
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue8(logic [7:0] a, logic [7:0] b, bit cin, bit sub, bit expect_it);
        exp_t e;
        start8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
        if (expect_it) begin
            e     = model(8, longint'(a), longint'(b), cin, sub);
            e.acc = cyc + 1;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic issue16(logic [15:0] a, logic [15:0] b, bit cin, bit sub);
        exp_t e;
        start16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub;
        e     = model(16, longint'(a), longint'(b), cin, sub);
        e.acc = cyc + 1;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
    endtask

    task automatic wait_idle8(string name);
        int n = 0;
        while ((q8.size() != 0 || busy8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({name, "_timeout"}, q8.size(), 0);
    endtask

    task automatic wait_idle16(string name);
        int n = 0;
        while ((q16.size() != 0 || busy16) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({name, "_timeout"}, q16.size(), 0);
    endtask

    task automatic wait_free8();
        int n = 0;
        while (busy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("free8_timeout", int'(busy8), 0);
    endtask

    task automatic wait_free16();
        int n = 0;
        while (busy16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("free16_timeout", int'(busy16), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish by 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        #2;
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_sum8", int'(sum8), 0);
        chk("rst_flags8", int'({c8, ovf8}), 0);
        chk("rst_out16", int'({busy16, done16, c16, ovf16, sum16}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry out of the MSB, busy for exactly 8 cycles
        issue8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        while (busy8 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles8", cnt, 8);
        wait_idle8("t1");
        chk("t1_literal", int'({c8, ovf8, sum8}), 10'h200);

        issue8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_idle8("t2");
        chk("t2_literal", int'({c8, ovf8, sum8}), 10'h080 | 10'h100);

        issue8(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
        wait_idle8("t3");
        chk("t3_literal", int'({c8, ovf8, sum8}), 10'h0FE);

        // Start while busy is ignored; start in the done cycle is accepted
        issue8(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        issue8(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (!done8 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("t4_sum_literal", int'(sum8), 8'h30);
        d1 = cyc;
        issue8(8'h40, 8'h41, 1'b1, 1'b0, 1'b1);
        wait_idle8("t4");
        chk("done_spacing8", last_done8 - d1, 9);
        chk("t4b_literal", int'({c8, ovf8, sum8}), 10'h182);

        // Reset mid-operation: immediate clear, no done
        issue8(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy8", int'(busy8), 0);
        chk("abort_done8", int'(done8), 0);
        chk("abort_sum8", int'(sum8), 0);
        chk("abort_flags8", int'({c8, ovf8}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue8(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        wait_idle8("t5");
        chk("t5_literal", int'(sum8), 8'h03);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            wait_free8();
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        wait_idle8("rand8");

        issue16(16'h1234, 16'hEDCC, 1'b0, 1'b0);
        wait_idle16("t6");
        chk("t6_literal", int'({c16, ovf16, sum16}), 18'h20000);

        for (int i = 0; i < 40; i++) begin
            wait_free16();
            issue16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_idle16("rand16");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
